// File: rtl/ycbcr_arb_pkg.sv
// Shared definitions for the YCbCr frame arbiter: FSM encoding, source ids, default latency.
package ycbcr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  localparam int unsigned CONV_LAT_DEF = 3;

  function automatic logic [1:0] src_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ycbcr_arb_edge_det.sv
// Registers a source vsync and emits one-clock frame start/end pulses.
// The pulses are suppressed on the first cycle after reset so a frame already in flight is not mistaken for a new one.
module ycbcr_arb_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic start_c,
  output logic end_c
);

  logic vsync_q;
  logic armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
      armed_q <= 1'b1;
    end
  end

  assign start_c = armed_q & vsync & ~vsync_q;
  assign end_c   = armed_q & ~vsync & vsync_q;

endmodule

// File: rtl/ycbcr_frame_arbiter.sv
// Frame-granular arbiter sharing one YCbCr-to-RGB converter between two camera streams.
// Build option YCBCR_ARB_FIXED_PRIO_EN: source 0 always wins simultaneous starts (no round-robin).
module ycbcr_frame_arbiter
  import ycbcr_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CONV_LAT = CONV_LAT_DEF,
  parameter int unsigned DROP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_en,
  input  logic              s0_frame_vsync,
  input  logic              s0_frame_href,
  input  logic              s0_frame_clken,
  input  logic [DATA_W-1:0] s0_img_Y,
  input  logic [DATA_W-1:0] s0_img_Cb,
  input  logic [DATA_W-1:0] s0_img_Cr,
  input  logic              s1_frame_vsync,
  input  logic              s1_frame_href,
  input  logic              s1_frame_clken,
  input  logic [DATA_W-1:0] s1_img_Y,
  input  logic [DATA_W-1:0] s1_img_Cb,
  input  logic [DATA_W-1:0] s1_img_Cr,
  output logic              conv_frame_vsync,
  output logic              conv_frame_href,
  output logic              conv_frame_clken,
  output logic [DATA_W-1:0] conv_img_Y,
  output logic [DATA_W-1:0] conv_img_Cb,
  output logic [DATA_W-1:0] conv_img_Cr,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              post_src_id,
  output logic [DROP_W-1:0] drop_cnt0,
  output logic [DROP_W-1:0] drop_cnt1
);

  localparam int unsigned CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  arb_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 owner_q, owner_d;
  logic                 rr_q, rr_d;
  logic                 start0_c, end0_c, start1_c, end1_c;
  logic                 owner_end_c, new_frame_c, pick_c;
  logic                 fwd_c, fwd_src_c, drop0_c, drop1_c;
  logic                 busy_d;
  logic [1:0]           grant_d;
  logic                 src_q;
  logic [CONV_LAT-1:0]  pipe_q;

  ycbcr_arb_edge_det u_edge0 (
    .clk     (clk),
    .rst     (rst),
    .vsync   (s0_frame_vsync),
    .start_c (start0_c),
    .end_c   (end0_c)
  );

  ycbcr_arb_edge_det u_edge1 (
    .clk     (clk),
    .rst     (rst),
    .vsync   (s1_frame_vsync),
    .start_c (start1_c),
    .end_c   (end1_c)
  );

  assign owner_end_c = (owner_q == SRC1) ? end1_c : end0_c;
  assign new_frame_c = arb_en & (start0_c | start1_c);
  assign pick_c      = (start0_c & start1_c) ? rr_q : start1_c;

  // State register plus the registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= SRC0;
      rr_q    <= SRC0;
      grant   <= 2'b00;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      grant   <= grant_d;
      busy    <= busy_d;
    end
  end

  // Next-state: stream whole frames, then drain the converter pipeline
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (new_frame_c) state_d = STREAM;
      end
      STREAM: begin
        if (owner_end_c) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(CONV_LAT - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: forwarding select, drop strobes, owner and round-robin pointer
  always_comb begin
    fwd_c     = 1'b0;
    fwd_src_c = owner_q;
    drop0_c   = 1'b0;
    drop1_c   = 1'b0;
    owner_d   = owner_q;
    rr_d      = rr_q;
    case (state_q)
      IDLE: begin
        if (new_frame_c) begin
          fwd_c     = 1'b1;
          fwd_src_c = pick_c;
          owner_d   = pick_c;
          drop0_c   = start0_c & start1_c & (pick_c == SRC1);
          drop1_c   = start0_c & start1_c & (pick_c == SRC0);
        end
      end
      STREAM: begin
        fwd_c   = 1'b1;
        drop0_c = arb_en & start0_c & (owner_q == SRC1);
        drop1_c = arb_en & start1_c & (owner_q == SRC0);
      end
      DRAIN: begin
        drop0_c = arb_en & start0_c;
        drop1_c = arb_en & start1_c;
        if (cnt_q == '0) begin
`ifdef YCBCR_ARB_FIXED_PRIO_EN
          rr_d = SRC0;
`else
          rr_d = ~owner_q;
`endif
        end
      end
      default: ;
    endcase
    busy_d  = (state_d != IDLE);
    grant_d = busy_d ? src_onehot(owner_d) : 2'b00;
  end

  // Converter-side datapath, source tag pipeline and drop counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_frame_vsync <= 1'b0;
      conv_frame_href  <= 1'b0;
      conv_frame_clken <= 1'b0;
      conv_img_Y       <= '0;
      conv_img_Cb      <= '0;
      conv_img_Cr      <= '0;
      src_q            <= SRC0;
      pipe_q           <= '0;
      drop_cnt0        <= '0;
      drop_cnt1        <= '0;
    end else begin
      if (fwd_c) begin
        conv_frame_vsync <= fwd_src_c ? s1_frame_vsync : s0_frame_vsync;
        conv_frame_href  <= fwd_src_c ? s1_frame_href  : s0_frame_href;
        conv_frame_clken <= fwd_src_c ? s1_frame_clken : s0_frame_clken;
        conv_img_Y       <= fwd_src_c ? s1_img_Y       : s0_img_Y;
        conv_img_Cb      <= fwd_src_c ? s1_img_Cb      : s0_img_Cb;
        conv_img_Cr      <= fwd_src_c ? s1_img_Cr      : s0_img_Cr;
        src_q            <= fwd_src_c;
      end else begin
        conv_frame_vsync <= 1'b0;
        conv_frame_href  <= 1'b0;
        conv_frame_clken <= 1'b0;
        conv_img_Y       <= '0;
        conv_img_Cb      <= '0;
        conv_img_Cr      <= '0;
      end
      pipe_q[0] <= src_q;
      for (int i = 1; i < int'(CONV_LAT); i++) pipe_q[i] <= pipe_q[i-1];
      if (drop0_c && (drop_cnt0 != '1)) drop_cnt0 <= drop_cnt0 + DROP_W'(1);
      if (drop1_c && (drop_cnt1 != '1)) drop_cnt1 <= drop_cnt1 + DROP_W'(1);
    end
  end

  assign post_src_id = pipe_q[CONV_LAT-1];

endmodule

// File: tb/tb_ycbcr_frame_arbiter.sv
// Self-checking bench for ycbcr_frame_arbiter: directed frame scenarios plus random traffic vs a frame-level model.
module tb_ycbcr_frame_arbiter;

  localparam int unsigned DW   = 8;
  localparam int unsigned LAT  = 3;
  localparam int unsigned DRW  = 4;
  localparam int          DMAX = (1 << DRW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arb_en = 1'b0;
  logic s0_frame_vsync = 1'b0, s0_frame_href = 1'b0, s0_frame_clken = 1'b0;
  logic s1_frame_vsync = 1'b0, s1_frame_href = 1'b0, s1_frame_clken = 1'b0;
  logic [DW-1:0] s0_img_Y = '0, s0_img_Cb = '0, s0_img_Cr = '0;
  logic [DW-1:0] s1_img_Y = '0, s1_img_Cb = '0, s1_img_Cr = '0;
  logic conv_frame_vsync, conv_frame_href, conv_frame_clken;
  logic [DW-1:0] conv_img_Y, conv_img_Cb, conv_img_Cr;
  logic [1:0] grant;
  logic busy, post_src_id;
  logic [DRW-1:0] drop_cnt0, drop_cnt1;

  int n_chk = 0;
  int n_pass = 0;

  // Staged stimulus applied on the next tick
  bit n_rst, n_en;
  bit n_v[2];

  // Reference model: frame owner, mode (0 idle, 1 streaming, 2 draining), drain cycles left
  int  m_mode, m_owner, m_drain, m_rr;
  int  m_drop[2];
  bit  m_armed;
  bit  m_prev[2];
  logic [3*DW+2:0] m_conv;
  logic [1:0] m_grant;
  bit  m_busy;
  bit  m_hist[LAT+1];

  always #5 clk = ~clk;

  ycbcr_frame_arbiter #(.DATA_W(DW), .CONV_LAT(LAT), .DROP_W(DRW)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .s0_frame_vsync(s0_frame_vsync), .s0_frame_href(s0_frame_href), .s0_frame_clken(s0_frame_clken),
    .s0_img_Y(s0_img_Y), .s0_img_Cb(s0_img_Cb), .s0_img_Cr(s0_img_Cr),
    .s1_frame_vsync(s1_frame_vsync), .s1_frame_href(s1_frame_href), .s1_frame_clken(s1_frame_clken),
    .s1_img_Y(s1_img_Y), .s1_img_Cb(s1_img_Cb), .s1_img_Cr(s1_img_Cr),
    .conv_frame_vsync(conv_frame_vsync), .conv_frame_href(conv_frame_href), .conv_frame_clken(conv_frame_clken),
    .conv_img_Y(conv_img_Y), .conv_img_Cb(conv_img_Cb), .conv_img_Cr(conv_img_Cr),
    .grant(grant), .busy(busy), .post_src_id(post_src_id),
    .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_drain = 0; m_rr = 0;
    m_drop[0] = 0; m_drop[1] = 0;
    m_armed = 1'b0; m_prev[0] = 1'b0; m_prev[1] = 1'b0;
    m_conv = '0; m_grant = 2'b00; m_busy = 1'b0;
    for (int k = 0; k <= LAT; k++) m_hist[k] = 1'b0;
  endtask

  task automatic bump(input int n);
    if (m_drop[n] < DMAX) m_drop[n]++;
  endtask

  // Advance the model by one clock using the inputs just applied
  task automatic model_step();
    bit v[2], st[2], en[2];
    bit fwd, newid;
    int id;
    logic [3*DW+2:0] px[2];
    if (rst) begin
      model_reset();
      return;
    end
    v[0] = s0_frame_vsync; v[1] = s1_frame_vsync;
    px[0] = {s0_frame_vsync, s0_frame_href, s0_frame_clken, s0_img_Y, s0_img_Cb, s0_img_Cr};
    px[1] = {s1_frame_vsync, s1_frame_href, s1_frame_clken, s1_img_Y, s1_img_Cb, s1_img_Cr};
    for (int n = 0; n < 2; n++) begin
      st[n] = m_armed && v[n] && !m_prev[n];
      en[n] = m_armed && !v[n] && m_prev[n];
    end
    fwd = 1'b0; id = 0;
    case (m_mode)
      0: if (arb_en && (st[0] || st[1])) begin
        id = (st[0] && st[1]) ? m_rr : (st[1] ? 1 : 0);
        if (st[0] && st[1]) bump(1 - id);
        m_owner = id; m_mode = 1; fwd = 1'b1;
      end
      1: begin
        id = m_owner; fwd = 1'b1;
        if (arb_en && st[1 - m_owner]) bump(1 - m_owner);
        if (en[m_owner]) begin m_mode = 2; m_drain = LAT; end
      end
      default: begin
        for (int n = 0; n < 2; n++) if (arb_en && st[n]) bump(n);
        m_drain--;
        if (m_drain == 0) begin
          m_mode = 0;
`ifdef YCBCR_ARB_FIXED_PRIO_EN
          m_rr = 0;
`else
          m_rr = 1 - m_owner;
`endif
        end
      end
    endcase
    m_conv  = fwd ? px[id] : '0;
    m_busy  = (m_mode != 0);
    m_grant = m_busy ? 2'(1 << m_owner) : 2'b00;
    newid = fwd ? (id != 0) : m_hist[0];
    for (int k = LAT; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = newid;
    m_prev[0] = v[0]; m_prev[1] = v[1];
    m_armed = 1'b1;
  endtask

  task automatic check_outputs();
    check("conv", 32'({conv_frame_vsync, conv_frame_href, conv_frame_clken, conv_img_Y, conv_img_Cb, conv_img_Cr}), 32'(m_conv));
    check("grant", 32'(grant), 32'(m_grant));
    check("busy", 32'(busy), 32'(m_busy));
    check("post_src_id", 32'(post_src_id), 32'(m_hist[LAT]));
    check("drop_cnt0", 32'(drop_cnt0), 32'(m_drop[0]));
    check("drop_cnt1", 32'(drop_cnt1), 32'(m_drop[1]));
  endtask

  // One clock: check outputs, apply staged inputs with random pixel payload, step the model
  task automatic tick();
    @(negedge clk);
    check_outputs();
    rst = n_rst; arb_en = n_en;
    s0_frame_vsync = n_v[0]; s0_frame_href = n_v[0] & 1'($urandom); s0_frame_clken = 1'($urandom);
    s1_frame_vsync = n_v[1]; s1_frame_href = n_v[1] & 1'($urandom); s1_frame_clken = 1'($urandom);
    s0_img_Y = DW'($urandom); s0_img_Cb = DW'($urandom); s0_img_Cr = DW'($urandom);
    s1_img_Y = DW'($urandom); s1_img_Cb = DW'($urandom); s1_img_Cr = DW'($urandom);
    model_step();
  endtask

  // Play a window where each source's vsync is high during [a, a+l)
  task automatic play(input int a0, input int l0, input int a1, input int l1, input int len);
    for (int c = 0; c < len; c++) begin
      n_v[0] = (c >= a0) && (c < a0 + l0);
      n_v[1] = (c >= a1) && (c < a1 + l1);
      tick();
    end
  endtask

  initial begin
    int rem[2];
    model_reset();
    n_rst = 1'b1; n_en = 1'b1; n_v[0] = 1'b0; n_v[1] = 1'b0;
    repeat (3) tick();
    n_rst = 1'b0;
    repeat (3) tick();

    play(2, 10, 2, 10, 20);     // simultaneous starts: source 0 first, source 1 dropped
    play(2, 10, 2, 10, 20);     // next simultaneous pair goes the other way unless fixed priority
    play(1, 30, -1, 0, 40);     // single source 0 frame, source 1 idle
    play(2, 20, 7, 10, 30);     // source 1 starts mid-frame of source 0
    play(2, 10, 13, 6, 24);     // source 1 rises during the drain gap
    play(-1, 0, 3, 8, 20);      // next source 1 frame is granted

    // Source 1 streams while source 0 keeps starting frames until its counter saturates
    n_v[0] = 1'b0; n_v[1] = 1'b1;
    for (int c = 0; c < 80; c++) begin
      n_v[0] = (c % 4) >= 2;
      tick();
    end
    n_v[0] = 1'b0; n_v[1] = 1'b0;
    repeat (8) tick();

    // Grants disabled with both sources active
    n_en = 1'b0;
    play(2, 10, 2, 10, 20);
    play(2, 10, 5, 10, 20);
    n_en = 1'b1;

    // Reset mid-frame, released while source 0 vsync is still high
    n_v[0] = 1'b1;
    repeat (6) tick();
    @(posedge clk);
    #2 rst = 1'b1; n_rst = 1'b1;
    model_reset();
    #1;
    check("rst_conv", 32'({conv_frame_vsync, conv_frame_href, conv_frame_clken, conv_img_Y, conv_img_Cb, conv_img_Cr}), 32'(m_conv));
    check("rst_grant", 32'(grant), 32'(m_grant));
    check("rst_busy", 32'(busy), 32'(m_busy));
    repeat (2) tick();
    n_rst = 1'b0;
    repeat (8) tick();
    n_v[0] = 1'b0; repeat (3) tick();
    n_v[0] = 1'b1; repeat (8) tick();
    n_v[0] = 1'b0; repeat (8) tick();

    // Random traffic with occasional arb_en-off phases
    rem[0] = 3; rem[1] = 7;
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (rem[n] == 0) begin
          n_v[n] = !n_v[n];
          rem[n] = n_v[n] ? int'($urandom_range(30, 4)) : int'($urandom_range(12, 1));
        end else begin
          rem[n]--;
        end
      end
      if (c % 200 == 0) n_en = ($urandom_range(3, 0) != 0);
      tick();
    end
    n_v[0] = 1'b0; n_v[1] = 1'b0; n_en = 1'b1;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
